// File: rtl/lsu_mem_if.sv
// lsu_mem_if: RV32I load/store unit in front of a word-addressed, byte-masked
// data memory with a one-cycle registered read.
module lsu_mem_if #(
    parameter int MEM_AW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic              op_we,
    input  logic [2:0]        op_funct3,
    input  logic [31:0]       op_addr,
    input  logic [31:0]       op_wdata,
    output logic              load_valid,
    output logic [31:0]       load_data,
    output logic              store_done,
    output logic              err,
    output logic              mem_request,
    output logic              mem_we_re,
    output logic [MEM_AW-1:0] mem_address,
    output logic [31:0]       mem_data_in,
    output logic [3:0]        mem_mask,
    input  logic [31:0]       mem_data_out
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state_reg, state_next;
    logic              we_reg;
    logic [2:0]        funct3_reg;
    logic [1:0]        off_reg;
    logic [MEM_AW-1:0] mem_address_reg;
    logic [31:0]       mem_data_in_reg;
    logic [3:0]        mem_mask_reg;
    logic [31:0]       load_data_reg;
    logic              load_valid_reg;
    logic              store_done_reg;
    logic              err_reg;

    logic              accept;
    logic              legal_f3;
    logic              misaligned;
    logic              accept_ok;
    logic              accept_bad;
    logic [3:0]        lane_mask;
    logic [31:0]       lane_wdata;
    logic [31:0]       shifted;
    logic [31:0]       load_ext;

    // Address bits above the memory range are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, op_addr[31:MEM_AW+2]};

    // Decode the request: legality, alignment, lane mask and replicated data.
    always_comb begin
        accept     = (state_reg == IDLE) && op_valid;
        legal_f3   = 1'b0;
        misaligned = 1'b0;
        lane_mask  = 4'b1111;
        lane_wdata = op_wdata;
        case (op_funct3)
            3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
            3'b100, 3'b101:         legal_f3 = !op_we;
            default:                legal_f3 = 1'b0;
        endcase
        case (op_funct3[1:0])
            2'b00: begin
                lane_mask  = 4'b0001 << op_addr[1:0];
                lane_wdata = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = op_addr[0];
                lane_mask  = 4'b0011 << op_addr[1:0];
                lane_wdata = {2{op_wdata[15:0]}};
            end
            default: begin
                misaligned = (op_addr[1:0] != 2'b00);
            end
        endcase
        accept_ok  = accept && legal_f3 && !misaligned;
        accept_bad = accept && !(legal_f3 && !misaligned);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake/strobe outputs.
    always_comb begin
        state_next  = state_reg;
        op_ready    = 1'b0;
        mem_request = 1'b0;
        mem_we_re   = 1'b0;
        case (state_reg)
            IDLE: begin
                op_ready = 1'b1;
                if (accept_ok) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mem_request = 1'b1;
                mem_we_re   = we_reg;
                state_next  = we_reg ? IDLE : WAIT;
            end
            WAIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the accepted transaction; memory-side fields hold until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_reg          <= 1'b0;
            funct3_reg      <= 3'b000;
            off_reg         <= 2'b00;
            mem_address_reg <= '0;
            mem_data_in_reg <= 32'h0;
            mem_mask_reg    <= 4'b0000;
        end else if (accept_ok) begin
            we_reg          <= op_we;
            funct3_reg      <= op_funct3;
            off_reg         <= op_addr[1:0];
            mem_address_reg <= op_addr[MEM_AW+1:2];
            mem_data_in_reg <= lane_wdata;
            // Loads present an all-zero mask so the memory never sees a write lane.
            mem_mask_reg    <= op_we ? lane_mask : 4'b0000;
        end
    end

    // Select the addressed lane from the read word and extend it.
    always_comb begin
        shifted = mem_data_out >> {off_reg, 3'b000};
        case (funct3_reg)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {24'h0, shifted[7:0]};
            3'b101:  load_ext = {16'h0, shifted[15:0]};
            default: load_ext = mem_data_out;
        endcase
    end

    // Completion pulses and the load result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_data_reg  <= 32'h0;
            load_valid_reg <= 1'b0;
            store_done_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            load_valid_reg <= (state_reg == WAIT);
            store_done_reg <= (state_reg == ISSUE) && we_reg;
            err_reg        <= accept_bad;
            if (state_reg == WAIT) begin
                load_data_reg <= load_ext;
            end
        end
    end

    assign load_valid  = load_valid_reg;
    assign load_data   = load_data_reg;
    assign store_done  = store_done_reg;
    assign err         = err_reg;
    assign mem_address = mem_address_reg;
    assign mem_data_in = mem_data_in_reg;
    assign mem_mask    = mem_mask_reg;

endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
Load/store unit between the pipeline memory stage and the word-addressed, byte-masked data memory. Accepts one RV32I load or store per transaction and converts its byte address into a word index, byte mask and lane-shifted write data. For loads it waits out the memory's one-cycle registered read, then extracts, sign- or zero-extends and returns the result with a one-cycle valid pulse. Busy while a transaction is in flight, so the pipeline stalls on op_ready.

Parameters:
MEM_AW, 8, word-address width driven to memory (memory depth 2^MEM_AW words)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
op_valid  in  1  transaction request from pipeline
op_ready  out  1  high when LSU can accept (IDLE only)
op_we  in  1  1 = store, 0 = load
op_funct3  in  3  RV32I funct3 (size/sign)
op_addr  in  32  byte address
op_wdata  in  32  store data, right-aligned
load_valid  out  1  one-cycle pulse, load_data valid
load_data  out  32  extended load result
store_done  out  1  one-cycle pulse, store written
err  out  1  one-cycle pulse, misaligned or illegal funct3, no memory access made
mem_request  out  1  memory request
mem_we_re  out  1  1 = write, 0 = read
mem_address  out  MEM_AW  word index
mem_data_in  out  32  lane-shifted write data
mem_mask  out  4  byte-lane write enables
mem_data_out  in  32  memory read data, valid the cycle after the read request edge

Behaviour:
- Reset: clk and rst as above; reset is asynchronous, active-high. On reset: state IDLE; op_ready=1; every other output 0, including all mem_* outputs. Reset mid-transaction abandons it, with no pulse afterwards.
- FSM: IDLE, ISSUE, WAIT.
- IDLE: op_ready=1. When op_valid=1 at an edge, decode:
  - Legal funct3: loads 000/001/010/100/101; stores 000/001/010.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
  - Illegal or misaligned: err=1 next cycle, remain IDLE, mem_request stays 0.
  - Otherwise register: mem_address=op_addr[MEM_AW+1:2]. Upper bits are ignored; no range error.
  - Otherwise register the mask: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
  - Otherwise register mem_data_in: op_wdata replicated into lanes, i.e. byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word as-is.
  - Otherwise latch funct3 and addr[1:0]; go ISSUE.
- ISSUE (exactly one cycle): mem_request=1, mem_we_re=op_we. Mask is driven for stores; for loads mem_mask=0000.
  - Store: next state IDLE, store_done=1 in that next cycle.
  - Load: next state WAIT.
- WAIT (exactly one cycle): mem_request=0. Select the byte/half at the latched offset from mem_data_out. Extend by funct3: LB/LH sign, LBU/LHU zero, LW pass-through. Register into load_data, load_valid=1 next cycle, state IDLE.
- Latency, with acceptance edge E0:
  - Store written at edge E1; store_done high in cycle after E1.
  - Load memory read at E1; load_data/load_valid high in cycle after E2.
- Throughput:
  - Load: one per 3 cycles.
  - Store: one per 2 cycles, because op_ready is low in ISSUE/WAIT and op_valid there is ignored.
  - A new op may be accepted in the same cycle a load_valid/store_done/err pulse is high. The pulse then remains exactly one cycle.
- mem_address/mem_data_in/mem_mask hold their last values outside ISSUE; mem_request is the only qualifier.
- load_data holds its value until the next completed load.
- load_valid, store_done and err are mutually exclusive in any cycle.

Test Plan:
- Reset mid-load: assert rst in WAIT -> all outputs 0 immediately (asynchronous); no load_valid pulse follows.
- SW 0xDEADBEEF to addr 0x10, then LW from 0x10 -> in ISSUE of the store: mem_address=4, mask=1111, we_re=1, store_done one cycle later. Load: load_valid exactly 3 cycles after acceptance, load_data=0xDEADBEEF, op_ready low for 2 cycles.
- SB 0x80 to addr 0x13, then LB from 0x13 / LBU from 0x13 -> store: mask=1000, mem_data_in=0x80808080. Loads: load_data=0xFFFFFF80 (LB) and 0x00000080 (LBU).
- SH 0x8001 to addr 0x22, then LH / LHU from 0x22 -> store: mask=1100, address=8. Loads: 0xFFFF8001 (LH) and 0x00008001 (LHU); byte lanes 0-1 of word 8 unchanged.
- LW from 0x05, LH from 0x03, funct3=011 load -> err pulse one cycle after each, mem_request never asserted, op_ready stays 1.
- op_valid held high across back-to-back loads -> accepted only in IDLE, one load per 3 cycles. load_valid and next acceptance coincide with no lost or duplicated transactions.
